seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
// - Time-multiplexes a 4-digit common-anode 7-segment display from a 28-bit parallel segment bus plus per-digit blank flags.
// - Receiving end of the hex-to-segment decoder output: seg_i[7k+6:7k] is digit k (active-low), blank_i[k]=1 suppresses digit k.
// - Adds frame-synchronous update (no tearing), a ghosting guard interval and an optional brightness PWM.
// PARAMETERS
// - TICK_DIV  default 100000  clk cycles per digit slot (1 kHz slot rate at 100 MHz); legal range >= 2.
// - GUARD     default 16      leading cycles of each slot with all digits off; legal range 0 <= GUARD < TICK_DIV.
// PORTS
// - clk         in   1   single clock, rising edge.
// - rst_n       in   1   asynchronous, active-low reset.
// - seg_i       in   28  segment codes, active-low, digit k at [7k+6:7k].
// - blank_i     in   4   1 = digit k dark.
// - load_i      in   1   capture seg_i/blank_i into staging this cycle.
// - load_ack_o  out  1   1-cycle pulse: staged data transferred to display shadow.
// - frame_o     out  1   1-cycle pulse at the start of every digit-0 slot.
// - seg_o       out  7   segment pins, active-low, registered.
// - an_n_o      out  4   anode enables, active-low, registered.
// - dim_i       in   4   brightness 0..15; present only with SEG_SCAN_DIM_EN.
// BEHAVIOUR
// - Reset (async, immediate): seg_o=7'h7F, an_n_o=4'hF, load_ack_o=0, frame_o=0; tick_cnt=0, idx=0; shadow seg=all 1s, shadow blank=4'hF; staging cleared, pending=0.
// - tick_cnt counts 0..TICK_DIV-1 and wraps. At the wrap, idx advances 0->1->2->3->0. One frame = 4*TICK_DIV cycles.
// - Phases within a slot:
//   - GUARD (tick_cnt < GUARD): an_n_o=4'hF, seg_o=7'h7F.
//   - DRIVE (otherwise): if shadow blank[idx]=0 then an_n_o=~(4'b1<<idx), seg_o=shadow seg[7*idx+:7]; else an_n_o=4'hF, seg_o=7'h7F.
// - Outputs are registered: pins reflect the counter state of the previous cycle (latency exactly 1 cycle).
// - Load handshake:
//   - load_i=1 writes staging and sets pending. Repeated loads before the boundary overwrite staging; the last one wins.
//   - The frame boundary is the cycle where idx wraps 3->0. If pending, or load_i=1 on that same cycle, shadow <= (load_i ? seg_i/blank_i : staging), pending clears, and load_ack_o pulses with the same registered timing as frame_o.
//   - Exactly one ack per boundary, however many loads preceded it. No ack when nothing is pending.
//   - Data transferred at a boundary is first visible in the DRIVE phase of the digit-0 slot that follows.
// - frame_o pulses every 4*TICK_DIV cycles, aligned with the first GUARD cycle of digit 0 on the pins.
// - Reset asserted mid-frame: pins go dark at once; a pending load is discarded; no ack is issued.
// - Counter widths are derived with $clog2(TICK_DIV); no overflow is possible within the legal parameter range.
// CONFIGURATION
// - Macro SEG_SCAN_DIM_EN.
//   - Defined: port dim_i exists and is sampled into shadow at every frame boundary (reset value 4'hF). In DRIVE, the digit is lit only when tick_cnt[3:0] <= dim_shadow; otherwise the pins show the GUARD pattern. dim=15 gives full brightness.
//   - Undefined: no dim_i port; DRIVE is lit for the whole phase.
// TESTING (TICK_DIV=8, GUARD=2 unless stated)
// - Reset: hold rst_n=0 -> seg_o=7F, an_n_o=F. Release -> pins dark for the whole first frame, because shadow blank=F.
// - Load seg_i={7'h00,7'h40,7'h79,7'h24}, blank_i=0 in the digit-1 slot -> no ack until the idx 3->0 wrap; ack and frame_o pulse on the same cycle.
//   Next frame, per slot: 2 cycles an_n_o=F, then 6 cycles at an_n_o=E/seg_o=24, D/79, B/40, 7/00.
// - Period check: frame_o spacing is exactly 32 cycles over 10 frames; idx order is 0,1,2,3 with no skips.
// - Two loads in one frame (0x...7F then 0x...00) -> one load_ack_o; only the second pattern is displayed.
// - load_i asserted exactly on the boundary cycle -> that value is displayed in the next frame with no extra frame of delay.
//   blank_i=4'b1100 -> an_n_o stays F through the slots of digits 2 and 3.
// - Reset mid-frame with a load pending -> immediate dark pins; no ack after release; old shadow is not restored.
// - SEG_SCAN_DIM_EN, dim_i=3 -> within each slot, digit lit only at tick_cnt 2 and 3. dim_i=15 -> lit at tick_cnt 2..7.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a 4-digit common-anode
// 7-segment display. Staged data moves into the display shadow only at the
// frame boundary (idx 3->0), so a frame never shows a mix of old and new data.
// Each digit slot starts with a GUARD-cycle all-dark interval to suppress ghosting.
// Optional brightness PWM is enabled by defining the macro SEG_SCAN_DIM_EN
// (adds the dim_i port). Without it, the digit is lit for the whole drive phase.
module seg7_scan_driver #(
  parameter int TICK_DIV = 100000,
  parameter int GUARD    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [27:0] seg_i,
  input  logic [3:0]  blank_i,
  input  logic        load_i,
`ifdef SEG_SCAN_DIM_EN
  input  logic [3:0]  dim_i,
`endif
  output logic        load_ack_o,
  output logic        frame_o,
  output logic [6:0]  seg_o,
  output logic [3:0]  an_n_o
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] tick_cnt_r;
  logic [1:0]    idx_r;
  logic [27:0]   stage_seg_r;
  logic [3:0]    stage_blank_r;
  logic          pending_r;
  logic [27:0]   shad_seg_r;
  logic [3:0]    shad_blank_r;
  logic          xfer_r;
`ifdef SEG_SCAN_DIM_EN
  logic [3:0]    dim_shad_r;
`endif

  logic          slot_end_s;
  logic          boundary_s;
  logic [31:0]   tick_ext_s;
  logic          in_guard_s;
  logic          lit_s;
  logic [6:0]    digit_seg_s;
  logic [3:0]    an_sel_s;

  assign slot_end_s = (tick_cnt_r == CW'(TICK_DIV - 1));
  assign boundary_s = slot_end_s && (idx_r == 2'd3);
  assign tick_ext_s = 32'(tick_cnt_r);
  assign in_guard_s = (tick_ext_s < 32'(GUARD));

  // Select the shadow segment code and anode pattern for the current digit.
  always_comb begin
    digit_seg_s = 7'h7F;
    an_sel_s    = 4'hF;
    case (idx_r)
      2'd0: begin digit_seg_s = shad_seg_r[6:0];   an_sel_s = 4'b1110; end
      2'd1: begin digit_seg_s = shad_seg_r[13:7];  an_sel_s = 4'b1101; end
      2'd2: begin digit_seg_s = shad_seg_r[20:14]; an_sel_s = 4'b1011; end
      2'd3: begin digit_seg_s = shad_seg_r[27:21]; an_sel_s = 4'b0111; end
      default: begin digit_seg_s = 7'h7F; an_sel_s = 4'hF; end
    endcase
  end

  // Decide whether the current digit is lit this cycle (guard, blank, PWM).
  always_comb begin
    lit_s = 1'b0;
    if (in_guard_s) begin
      lit_s = 1'b0;
    end else if (shad_blank_r[idx_r]) begin
      lit_s = 1'b0;
    end else begin
`ifdef SEG_SCAN_DIM_EN
      lit_s = (tick_ext_s[3:0] <= dim_shad_r);
`else
      lit_s = 1'b1;
`endif
    end
  end

  // Slot timer and digit index: tick wraps every TICK_DIV cycles, idx follows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_r <= '0;
      idx_r      <= 2'd0;
    end else if (slot_end_s) begin
      tick_cnt_r <= '0;
      idx_r      <= idx_r + 2'd1;
    end else begin
      tick_cnt_r <= tick_cnt_r + CW'(1);
      idx_r      <= idx_r;
    end
  end

  // Load handshake: stage loads, transfer to shadow only at the frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_seg_r   <= 28'h0000000;
      stage_blank_r <= 4'h0;
      pending_r     <= 1'b0;
      shad_seg_r    <= 28'hFFFFFFF;
      shad_blank_r  <= 4'hF;
      xfer_r        <= 1'b0;
    end else if (boundary_s) begin
      if (load_i) begin
        shad_seg_r   <= seg_i;
        shad_blank_r <= blank_i;
      end else if (pending_r) begin
        shad_seg_r   <= stage_seg_r;
        shad_blank_r <= stage_blank_r;
      end else begin
        shad_seg_r   <= shad_seg_r;
        shad_blank_r <= shad_blank_r;
      end
      xfer_r    <= load_i | pending_r;
      pending_r <= 1'b0;
    end else begin
      xfer_r <= 1'b0;
      if (load_i) begin
        stage_seg_r   <= seg_i;
        stage_blank_r <= blank_i;
        pending_r     <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

`ifdef SEG_SCAN_DIM_EN
  // Brightness is resampled once per frame so a frame has uniform intensity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dim_shad_r <= 4'hF;
    end else if (boundary_s) begin
      dim_shad_r <= dim_i;
    end else begin
      dim_shad_r <= dim_shad_r;
    end
  end
`endif

  // Registered pins; the ack is delayed one cycle so it coincides with frame_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_o      <= 7'h7F;
      an_n_o     <= 4'hF;
      frame_o    <= 1'b0;
      load_ack_o <= 1'b0;
    end else begin
      seg_o      <= lit_s ? digit_seg_s : 7'h7F;
      an_n_o     <= lit_s ? an_sel_s : 4'hF;
      frame_o    <= (tick_cnt_r == '0) && (idx_r == 2'd0);
      load_ack_o <= xfer_r;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (TICK_DIV=8, GUARD=2).
// The reference model tracks the position in the 32-cycle frame from a
// cycle count since reset and applies the load/transfer rules directly.
module tb_seg7_scan_driver;

  localparam int TD = 8;
  localparam int GD = 2;
  localparam int FRAME = 4 * TD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [27:0] seg_i = 28'h0;
  logic [3:0]  blank_i = 4'h0;
  logic        load_i = 1'b0;
  logic        load_ack_o;
  logic        frame_o;
  logic [6:0]  seg_o;
  logic [3:0]  an_n_o;
`ifdef SEG_SCAN_DIM_EN
  logic [3:0]  dim_i = 4'hF;
`endif

  seg7_scan_driver #(.TICK_DIV(TD), .GUARD(GD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_i      (seg_i),
    .blank_i    (blank_i),
    .load_i     (load_i),
`ifdef SEG_SCAN_DIM_EN
    .dim_i      (dim_i),
`endif
    .load_ack_o (load_ack_o),
    .frame_o    (frame_o),
    .seg_o      (seg_o),
    .an_n_o     (an_n_o)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model state
  int          n;
  logic [27:0] m_seg;
  logic [3:0]  m_blank;
  logic [27:0] m_stage_seg;
  logic [3:0]  m_stage_blank;
  logic        m_pend;
  logic        m_xfer;
  int          m_dim;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0;
    m_seg = 28'hFFFFFFF;
    m_blank = 4'hF;
    m_stage_seg = 28'h0;
    m_stage_blank = 4'h0;
    m_pend = 1'b0;
    m_xfer = 1'b0;
    m_dim = 15;
  endtask

  // Called at a negedge: drive inputs, take one posedge, check at next negedge.
  task automatic run_cycle(input logic ld, input logic [27:0] s, input logic [3:0] b);
    int p, slot, t;
    logic lit, e_frame, e_ack;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    load_i = ld; seg_i = s; blank_i = b;
    @(posedge clk);
    p = n % FRAME;
    slot = p / TD;
    t = p % TD;
    e_frame = (p == 0);
    e_ack = (p == 0) && m_xfer;
    lit = (t >= GD) && !m_blank[slot] && (t <= m_dim);
    e_seg = lit ? m_seg[7*slot +: 7] : 7'h7F;
    e_an = lit ? ~(4'b0001 << slot) : 4'hF;
    m_xfer = 1'b0;
    if (p == FRAME - 1) begin
      if (ld) begin
        m_seg = s; m_blank = b; m_xfer = 1'b1;
      end else if (m_pend) begin
        m_seg = m_stage_seg; m_blank = m_stage_blank; m_xfer = 1'b1;
      end
      m_pend = 1'b0;
`ifdef SEG_SCAN_DIM_EN
      m_dim = int'(dim_i);
`endif
    end else if (ld) begin
      m_stage_seg = s; m_stage_blank = b; m_pend = 1'b1;
    end
    n++;
    @(negedge clk);
    check("seg_o", 32'(seg_o), 32'(e_seg));
    check("an_n_o", 32'(an_n_o), 32'(e_an));
    check("frame_o", 32'(frame_o), 32'(e_frame));
    check("load_ack_o", 32'(load_ack_o), 32'(e_ack));
  endtask

  // Idle until the next edge lands on frame position tgt (bounded to one frame).
  task automatic idle_to(input int tgt);
    for (int k = 0; k < FRAME; k++) begin
      if ((n % FRAME) == tgt) break;
      run_cycle(1'b0, 28'h0, 4'h0);
    end
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) run_cycle(1'b0, 28'h0, 4'h0);
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_seg"}, 32'(seg_o), 32'h7F);
    check({tag, "_an"}, 32'(an_n_o), 32'hF);
    check({tag, "_ack"}, 32'(load_ack_o), 32'h0);
    check({tag, "_frame"}, 32'(frame_o), 32'h0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 check_dark("rst_async");
    @(negedge clk);
    @(negedge clk);
    check_dark("rst_hold");
    rst_n = 1'b1;
    model_reset();

    // First frame after reset is dark (shadow blank=F)
    idle(FRAME);

    // Load in digit-1 slot; ack at the boundary, displayed next frame
    idle_to(10);
    run_cycle(1'b1, {7'h00, 7'h40, 7'h79, 7'h24}, 4'h0);
    idle(2 * FRAME);

    // Two loads in one frame: only the second is shown, one ack
    idle_to(5);
    run_cycle(1'b1, 28'hFFFFF7F, 4'h0);
    idle_to(20);
    run_cycle(1'b1, 28'h0000000, 4'h0);
    idle(2 * FRAME);

    // Load exactly on the boundary cycle with digits 2,3 blanked
    idle_to(FRAME - 1);
    run_cycle(1'b1, 28'h1234567, 4'b1100);
    idle(FRAME + 4);

    // Mid-frame reset with a load pending
    idle_to(9);
    run_cycle(1'b1, 28'h0A5A5A5, 4'h0);
    idle(3);
    rst_n = 1'b0;
    #1 check_dark("rst_mid");
    @(negedge clk);
    check_dark("rst_mid_hold");
    rst_n = 1'b1;
    model_reset();
    idle(2 * FRAME);

`ifdef SEG_SCAN_DIM_EN
    // Brightness levels 3 and 15 on a fully lit pattern
    idle_to(0);
    dim_i = 4'd3;
    idle_to(FRAME - 1);
    run_cycle(1'b1, 28'h0000000, 4'h0);
    idle(FRAME);
    dim_i = 4'd15;
    idle(2 * FRAME);
`endif

    // Randomized loads, data, blanking and brightness
    for (int k = 0; k < 800; k++) begin
`ifdef SEG_SCAN_DIM_EN
      dim_i = 4'($urandom_range(0, 15));
`endif
      run_cycle(($urandom_range(0, 9) == 0), 28'($urandom), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
